// File: rtl/result_frame_rx.sv
// result_frame_rx: reassembles 10-byte result frames (header, word_a, word_b, xor checksum).
// Ports: clk/rst_n, ena, in_byte/in_valid in; busy, res_valid, mode, word_a, word_b,
//        err_chk, err_timeout, frame_cnt out.
module result_frame_rx #(
  parameter logic [3:0] SYNC           = 4'hA,
  parameter int         TIMEOUT_CYCLES = 64,
  parameter int         CW             = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        busy,
  output logic        res_valid,
  output logic [2:0]  mode,
  output logic [31:0] word_a,
  output logic [31:0] word_b,
  output logic        err_chk,
  output logic        err_timeout,
  output logic [7:0]  frame_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_A,
    S_B,
    S_CHK
  } state_e;

  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_e        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [7:0]    sum_q, sum_d;
  logic [2:0]    mtmp_q, mtmp_d;
  logic [31:0]   tmp_a_q, tmp_a_d;
  logic [31:0]   tmp_b_q, tmp_b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    mode_q, mode_d;
  logic [31:0]   word_a_q, word_a_d;
  logic [31:0]   word_b_q, word_b_d;
  logic          rv_q, rv_d;
  logic          ec_q, ec_d;
  logic          et_q, et_d;
  logic [7:0]    fcnt_q, fcnt_d;
  logic          is_hdr;

  assign is_hdr = (in_byte[7:4] == SYNC) && !in_byte[3];

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sum_d    = sum_q;
    mtmp_d   = mtmp_q;
    tmp_a_d  = tmp_a_q;
    tmp_b_d  = tmp_b_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    word_a_d = word_a_q;
    word_b_d = word_b_q;
    fcnt_d   = fcnt_q;
    rv_d     = 1'b0;
    ec_d     = 1'b0;
    et_d     = 1'b0;
    if (state_q == S_IDLE) begin
      cnt_d = '0;
      if (ena && in_valid && is_hdr) begin
        mtmp_d  = in_byte[2:0];
        sum_d   = in_byte;
        idx_d   = 4'd1;
        state_d = S_A;
      end
    end else if (ena) begin
      if (in_valid) begin
        cnt_d = '0;
        sum_d = sum_q ^ in_byte;
        idx_d = idx_q + 4'd1;
        unique case (1'b1)
          state_q == S_A: begin
            tmp_a_d = {tmp_a_q[23:0], in_byte};
            if (idx_q == 4'd4) state_d = S_B;
          end
          state_q == S_B: begin
            tmp_b_d = {tmp_b_q[23:0], in_byte};
            if (idx_q == 4'd8) state_d = S_CHK;
          end
          default: begin
            // checksum byte: commit all three fields at once or none
            if (in_byte == sum_q) begin
              mode_d   = mtmp_q;
              word_a_d = tmp_a_q;
              word_b_d = tmp_b_q;
              fcnt_d   = fcnt_q + 8'd1;
              rv_d     = 1'b1;
            end else begin
              ec_d = 1'b1;
            end
            idx_d   = 4'd0;
            state_d = S_IDLE;
          end
        endcase
      end else if (cnt_q == TO_LAST) begin
        // this idle cycle is the TIMEOUT_CYCLES-th since the last byte
        et_d    = 1'b1;
        cnt_d   = '0;
        idx_d   = 4'd0;
        state_d = S_IDLE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      sum_q    <= '0;
      mtmp_q   <= '0;
      tmp_a_q  <= '0;
      tmp_b_q  <= '0;
      cnt_q    <= '0;
      mode_q   <= '0;
      word_a_q <= '0;
      word_b_q <= '0;
      fcnt_q   <= '0;
      rv_q     <= 1'b0;
      ec_q     <= 1'b0;
      et_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      sum_q    <= sum_d;
      mtmp_q   <= mtmp_d;
      tmp_a_q  <= tmp_a_d;
      tmp_b_q  <= tmp_b_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      word_a_q <= word_a_d;
      word_b_q <= word_b_d;
      fcnt_q   <= fcnt_d;
      rv_q     <= rv_d;
      ec_q     <= ec_d;
      et_q     <= et_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign res_valid   = rv_q;
  assign err_chk     = ec_q;
  assign err_timeout = et_q;
  assign mode        = mode_q;
  assign word_a      = word_a_q;
  assign word_b      = word_b_q;
  assign frame_cnt   = fcnt_q;

endmodule

// File: tb/tb_result_frame_rx.sv
// tb_result_frame_rx: directed + random frames against a frame-level queue model.
// Ports: none (drives result_frame_rx).
module tb_result_frame_rx;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic [7:0]  in_byte = 8'h00;
  logic        in_valid = 1'b0;
  logic        busy;
  logic        res_valid;
  logic [2:0]  mode;
  logic [31:0] word_a;
  logic [31:0] word_b;
  logic        err_chk;
  logic        err_timeout;
  logic [7:0]  frame_cnt;

  result_frame_rx #(
    .SYNC(4'hA),
    .TIMEOUT_CYCLES(TO),
    .CW(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .in_byte(in_byte),
    .in_valid(in_valid),
    .busy(busy),
    .res_valid(res_valid),
    .mode(mode),
    .word_a(word_a),
    .word_b(word_b),
    .err_chk(err_chk),
    .err_timeout(err_timeout),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // model: bytes of the frame in progress plus idle cycles since last byte
  logic [7:0]  fq[$];
  int          gap;
  logic [2:0]  e_mode;
  logic [31:0] e_a, e_b;
  logic [7:0]  e_cnt;
  logic        e_rv, e_ec, e_et;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    fq.delete();
    gap = 0;
    e_mode = '0; e_a = '0; e_b = '0; e_cnt = '0;
    e_rv = 0; e_ec = 0; e_et = 0;
  endtask

  task automatic close_frame();
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < 9; i++) x ^= fq[i];
    if (x == fq[9]) begin
      e_mode = fq[0][2:0];
      e_a = {fq[1], fq[2], fq[3], fq[4]};
      e_b = {fq[5], fq[6], fq[7], fq[8]};
      e_cnt = e_cnt + 8'd1;
      e_rv = 1;
    end else begin
      e_ec = 1;
    end
    fq.delete();
  endtask

  task automatic model_step(input logic v, input logic [7:0] b,
                            input logic e);
    e_rv = 0; e_ec = 0; e_et = 0;
    if (e) begin
      if (fq.size() == 0) begin
        if (v && b[7:4] == 4'hA && !b[3]) begin
          fq.push_back(b);
          gap = 0;
        end
      end else if (v) begin
        fq.push_back(b);
        gap = 0;
        if (fq.size() == 10) close_frame();
      end else if (gap + 1 >= TO) begin
        e_et = 1;
        fq.delete();
        gap = 0;
      end else begin
        gap++;
      end
    end
  endtask

  task automatic check_all();
    chk("busy", busy, fq.size() != 0);
    chk("res_valid", res_valid, e_rv);
    chk("err_chk", err_chk, e_ec);
    chk("err_timeout", err_timeout, e_et);
    chk("mode", mode, e_mode);
    chk("word_a", word_a, e_a);
    chk("word_b", word_b, e_b);
    chk("frame_cnt", frame_cnt, e_cnt);
    chk("excl", 64'(res_valid + err_chk + err_timeout) <= 1, 1);
  endtask

  task automatic cyc(input logic v, input logic [7:0] b, input logic e);
    in_valid = v;
    in_byte  = b;
    ena      = e;
    @(posedge clk);
    model_step(v, b, e);
    #1;
    check_all();
  endtask

  task automatic build(input logic [2:0] m, input logic [31:0] a,
                      input logic [31:0] b, input bit bad,
                      output logic [7:0] fb[10]);
    logic [7:0] x;
    fb[0] = {4'hA, 1'b0, m};
    for (int i = 0; i < 4; i++) fb[1+i] = a[31-8*i -: 8];
    for (int i = 0; i < 4; i++) fb[5+i] = b[31-8*i -: 8];
    x = 8'h00;
    for (int i = 0; i < 9; i++) x ^= fb[i];
    fb[9] = bad ? (x ^ 8'h01) : x;
  endtask

  task automatic send_frame(input logic [2:0] m, input logic [31:0] a,
                            input logic [31:0] b, input bit bad,
                            input int g);
    logic [7:0] fb[10];
    build(m, a, b, bad, fb);
    for (int i = 0; i < 10; i++) begin
      cyc(1, fb[i], 1);
      if (i < 9) repeat (g) cyc(0, 8'h00, 1);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_busy", busy, 0);
    chk("rst_rv", res_valid, 0);
    chk("rst_mode", mode, 0);
    chk("rst_wa", word_a, 0);
    chk("rst_wb", word_b, 0);
    chk("rst_cnt", frame_cnt, 0);
    chk("rst_err", {err_chk, err_timeout}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] fb[10];
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // 1: basic frame
    send_frame(3'd2, 32'h00010000, 32'hFFFF8000, 0, 0);
    chk("t1_rv", res_valid, 1);
    chk("t1_mode", mode, 2);
    chk("t1_wa", word_a, 32'h00010000);
    chk("t1_wb", word_b, 32'hFFFF8000);
    chk("t1_cnt", frame_cnt, 1);
    chk("t1_busy", busy, 0);
    cyc(0, 8'h00, 1);
    chk("t1_rv_off", res_valid, 0);

    // 2: corrupted checksum
    send_frame(3'd6, 32'h12345678, 32'h9ABCDEF0, 1, 0);
    chk("t2_ec", err_chk, 1);
    chk("t2_rv", res_valid, 0);
    chk("t2_wa", word_a, 32'h00010000);
    chk("t2_mode", mode, 2);
    chk("t2_cnt", frame_cnt, 1);

    // 3: junk in IDLE
    cyc(1, 8'h55, 1);
    cyc(1, 8'h3C, 1);
    chk("t3_busy", busy, 0);
    send_frame(3'd3, 32'hDEADBEEF, 32'h00000001, 0, 0);
    chk("t3_rv", res_valid, 1);

    // 4: timeout after 64 idle cycles
    build(3'd4, 32'h01020304, 32'h05060708, 0, fb);
    for (int i = 0; i < 4; i++) cyc(1, fb[i], 1);
    repeat (TO - 1) cyc(0, 8'h00, 1);
    chk("t4_pre", err_timeout, 0);
    cyc(0, 8'h00, 1);
    chk("t4_to", err_timeout, 1);
    chk("t4_busy", busy, 0);
    send_frame(3'd7, 32'h80000000, 32'h7FFFFFFF, 0, TO - 1);
    chk("t4_rv", res_valid, 1);

    // 5: back-to-back
    send_frame(3'd1, 32'hCAFEF00D, 32'h0BADBEEF, 0, 0);
    send_frame(3'd5, 32'h11111111, 32'h22222222, 0, 0);
    chk("t5_mode", mode, 5);

    // 6a: ena low mid-frame, bytes offered meanwhile
    build(3'd0, 32'hA5A5A5A5, 32'h5A5A5A5A, 0, fb);
    for (int i = 0; i < 5; i++) cyc(1, fb[i], 1);
    repeat (200) cyc(1'($urandom), 8'($urandom), 0);
    for (int i = 5; i < 10; i++) cyc(1, fb[i], 1);
    chk("t6_rv", res_valid, 1);
    chk("t6_wa", word_a, 32'hA5A5A5A5);

    // 6b: reset mid-frame
    for (int i = 0; i < 5; i++) cyc(1, fb[i], 1);
    do_reset();
    send_frame(3'd6, 32'h00000042, 32'hFFFFFFFE, 0, 0);
    chk("t6_cnt", frame_cnt, 1);

    // random phase
    for (int it = 0; it < 150; it++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        cyc(1, 8'($urandom), 1);
      end else if (sel == 1) begin
        repeat ($urandom_range(1, 40)) cyc(1'($urandom), 8'($urandom), 0);
      end else if (sel == 2 && it % 7 == 0) begin
        do_reset();
      end else begin
        build(3'($urandom), $urandom, $urandom, ($urandom_range(0, 4) == 0), fb);
        for (int i = 0; i < 10; i++) begin
          cyc(1, fb[i], ($urandom_range(0, 5) != 0) ? 1'b1 : 1'b1);
          if ($urandom_range(0, 5) == 0)
            repeat ($urandom_range(1, 5)) cyc(1'($urandom), 8'($urandom), 0);
          if ($urandom_range(0, 25) == 0)
            repeat ($urandom_range(60, 68)) cyc(0, 8'h00, 1);
          else if ($urandom_range(0, 3) == 0)
            repeat ($urandom_range(1, 3)) cyc(0, 8'h00, 1);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
